// File: rtl/simple_uart_tx_arbiter.sv
// rtl/simple_uart_tx_arbiter.sv - per-message arbiter pacing NREQ byte streams into one simple_uart TX
// Define SIMPLE_UART_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module simple_uart_tx_arbiter #(
  parameter int SYSTEM_FREQ = 50_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int NREQ        = 4
) (
  input  logic              clock,
  input  logic              arst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [7:0]        tx_value,
  output logic              tx_value_write
);

  localparam int BIT_CYCLES  = SYSTEM_FREQ / BAUD_RATE;
  localparam int BYTE_CYCLES = 11 * BIT_CYCLES;
  localparam int CNT_W       = $clog2(BYTE_CYCLES);
  localparam int PTR_W       = $clog2(NREQ);

  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BYTE_CYCLES - 2);
  localparam logic [NREQ-1:0]  GRANT_ONE = NREQ'(1);

  generate
    if (BIT_CYCLES < 2 || NREQ < 2 || NREQ > 8) begin : g_param_check
      $error("simple_uart_tx_arbiter: illegal SYSTEM_FREQ/BAUD_RATE/NREQ");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [7:0]        tx_value_q, tx_value_d;
  logic              tx_write_q, tx_write_d;
  logic [PTR_W-1:0]  start_ptr;
  logic [PTR_W-1:0]  sel_idx;
  logic              sel_found;
  logic [7:0]        req_byte [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_bytes
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

`ifdef SIMPLE_UART_ARB_FIXED_PRIO_EN
  assign start_ptr = '0;
`else
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  assign start_ptr = rr_ptr_q;
`endif

  // First valid requester at or after start_ptr, wrapping modulo NREQ.
  always_comb begin : sel_search
    logic [PTR_W:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, start_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NREQ)) begin
        cand = cand - (PTR_W+1)'(NREQ);
      end
      if (!sel_found && req_valid[cand[PTR_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin : fsm_next
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    tx_value_d = tx_value_q;
    tx_write_d = 1'b0;
    req_ready  = '0;
`ifndef SIMPLE_UART_ARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = GRANT_ONE << sel_idx;
          owner_d = sel_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        req_ready = grant_q;
        if (req_valid[owner_q]) begin
          tx_value_d = req_byte[owner_q];
          last_d     = req_last[owner_q];
          tx_write_d = 1'b1;
          cnt_d      = CNT_LOAD;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (last_q) begin
`ifndef SIMPLE_UART_ARB_FIXED_PRIO_EN
            rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + PTR_W'(1);
`endif
            grant_d = '0;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      tx_value_q <= 8'h00;
      tx_write_q <= 1'b0;
`ifndef SIMPLE_UART_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      tx_value_q <= tx_value_d;
      tx_write_q <= tx_write_d;
`ifndef SIMPLE_UART_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign grant          = grant_q;
  assign busy           = (state_q != IDLE);
  assign tx_value       = tx_value_q;
  assign tx_value_write = tx_write_q;

endmodule

// File: tb/tb_simple_uart_tx_arbiter.sv
// tb/tb_simple_uart_tx_arbiter.sv - directed and randomized checks of simple_uart_tx_arbiter
module tb_simple_uart_tx_arbiter;

  localparam int NREQ        = 4;
  localparam int BYTE_CYCLES = 110;

  logic              clock = 1'b0;
  logic              arst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [7:0]        tx_value;
  logic              tx_value_write;

  simple_uart_tx_arbiter #(
    .SYSTEM_FREQ(1000),
    .BAUD_RATE  (100),
    .NREQ       (NREQ)
  ) dut (
    .clock         (clock),
    .arst_n        (arst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .grant         (grant),
    .busy          (busy),
    .tx_value      (tx_value),
    .tx_value_write(tx_value_write)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    int val;
    int own;
  } ev_t;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  int rr_m   = 0;
  logic [8:0]      drv_q [NREQ][$];
  logic [NREQ-1:0] hold = '0;
  logic [NREQ-1:0] acc  = '0;
  ev_t obs_q[$];
  ev_t exp_q[$];

  function automatic ev_t mk_ev(input int c, input int v, input int o);
    ev_t e;
    e.cyc = c;
    e.val = v;
    e.own = o;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (drv_q[i].size() > 0 && !hold[i]) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = drv_q[i][0][7:0];
        req_last[i]         = drv_q[i][0][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  // One clock: retire handshakes from the previous edge, log writes, re-drive inputs.
  task automatic step();
    @(posedge clock);
    cyc++;
    @(negedge clock);
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) void'(drv_q[i].pop_front());
    end
    if (tx_value_write) obs_q.push_back(mk_ev(cyc, int'(tx_value), int'(grant)));
    drive();
    #1;
    acc = req_valid & req_ready;
  endtask

  task automatic start();
    cyc = 0;
    obs_q.delete();
    drive();
    #1;
    acc = req_valid & req_ready;
  endtask

  // Transaction-level model: every queued message is valid continuously from cycle 0.
  task automatic predict(output int s_end);
    logic [8:0] mq [NREQ][$];
    logic [8:0] b;
    int s, own, first, n;
    for (int i = 0; i < NREQ; i++) mq[i] = drv_q[i];
    exp_q.delete();
    s = 0;
    while (1) begin
`ifdef SIMPLE_UART_ARB_FIXED_PRIO_EN
      first = 0;
`else
      first = rr_m;
`endif
      own = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (own < 0 && mq[(first + k) % NREQ].size() > 0) own = (first + k) % NREQ;
      end
      if (own < 0) break;
      n = 0;
      do begin
        b = mq[own].pop_front();
        exp_q.push_back(mk_ev(s + 2 + BYTE_CYCLES * n, int'(b[7:0]), 1 << own));
        n++;
      end while (!b[8]);
      s = s + 1 + BYTE_CYCLES * n;
      rr_m = (own + 1) % NREQ;
    end
    s_end = s;
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_write"},
            {32'(obs_q[i].cyc), 16'(obs_q[i].val), 16'(obs_q[i].own)},
            {32'(exp_q[i].cyc), 16'(exp_q[i].val), 16'(exp_q[i].own)});
    end
  endtask

  initial begin
    int s_end, bad, nm, len, who;
    logic [3:0] g112;

    // Reset with random inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      req_valid = 4'($urandom);
      req_data  = $urandom;
      req_last  = 4'($urandom);
    end
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_txval", 64'(tx_value), 64'(0));
    check("rst_txwr", 64'(tx_value_write), 64'(0));
    drive();
    arst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("post_rst_busy", 64'(busy), 64'(0));
    check("post_rst_grant", 64'(grant), 64'(0));

    // Round-robin: req0 has two single-byte messages, req1 one
    drv_q[0].push_back(9'h1A0);
    drv_q[0].push_back(9'h1A1);
    drv_q[1].push_back(9'h1B0);
    predict(s_end);
`ifdef SIMPLE_UART_ARB_FIXED_PRIO_EN
    g112 = 4'b0001;
`else
    g112 = 4'b0010;
`endif
    start();
    while (cyc < s_end + 3) begin
      step();
      if (cyc == 1)   check("rr_grant_c1", 64'(grant), 64'(4'b0001));
      if (cyc == 112) check("rr_grant_c112", 64'(grant), 64'(g112));
    end
    compare_events("rr");
    check("rr_idle", 64'(busy), 64'(0));

    // Requester 2, three bytes
    drv_q[2].push_back(9'h041);
    drv_q[2].push_back(9'h042);
    drv_q[2].push_back(9'h143);
    predict(s_end);
    start();
    while (cyc < 335) begin
      step();
      if (cyc == 1) begin
        check("r2_grant_c1", 64'(grant), 64'(4'b0100));
        check("r2_ready_c1", 64'(req_ready), 64'(4'b0100));
      end
      if (cyc == 330) check("r2_grant_c330", 64'(grant), 64'(4'b0100));
      if (cyc == 331) check("r2_grant_c331", 64'(grant), 64'(0));
    end
    check("r2_end_cycle", 64'(s_end), 64'(331));
    compare_events("r2");

    // Owner stall: req3 stops after its first byte while req0 waits
    drv_q[3].push_back(9'h030);
    drv_q[3].push_back(9'h131);
    exp_q.delete();
    exp_q.push_back(mk_ev(2, 'h30, 8));
    exp_q.push_back(mk_ev(502, 'h31, 8));
    exp_q.push_back(mk_ev(613, 'h55, 1));
    start();
    step();
    check("stall_grant_c1", 64'(grant), 64'(4'b1000));
    hold[3] = 1'b1;
    drv_q[0].push_back(9'h155);
    bad = 0;
    while (cyc < 500) begin
      step();
      if (grant !== 4'b1000 || req_ready[0] !== 1'b0) bad++;
    end
    check("stall_lock", 64'(bad), 64'(0));
    hold[3] = 1'b0;
    while (cyc < 620) begin
      step();
      if (cyc == 611) check("stall_grant_c611", 64'(grant), 64'(0));
      if (cyc == 612) check("stall_grant_c612", 64'(grant), 64'(4'b0001));
    end
    rr_m = 1;
    while (busy && cyc < 800) step();
    check("stall_idle", 64'(busy), 64'(0));
    compare_events("stall");

    // Reset in WAIT mid-message
    drv_q[1].push_back(9'h061);
    drv_q[1].push_back(9'h062);
    drv_q[1].push_back(9'h163);
    start();
    while (cyc < 50) step();
    check("mid_busy", 64'(busy), 64'(1));
    #2;
    arst_n = 1'b0;
    #1;
    check("mid_rst_out", {60'(grant), 4'(req_ready)}, 64'(0));
    check("mid_rst_tx", {55'(tx_value), tx_value_write, 8'(busy)}, 64'(0));
    for (int i = 0; i < NREQ; i++) drv_q[i].delete();
    acc = '0;
    drive();
    step();
    step();
    arst_n = 1'b1;
    rr_m = 0;
    obs_q.delete();
    for (int i = 0; i < 300; i++) step();
    check("mid_no_write", 64'(obs_q.size()), 64'(0));
    check("mid_idle", 64'(busy), 64'(0));

    // Randomized message mixes against the model
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) drv_q[i].push_back({(b == len - 1), 8'($urandom)});
        end
      end
      if (drv_q[0].size() + drv_q[1].size() + drv_q[2].size() + drv_q[3].size() == 0) begin
        who = $urandom_range(0, 3);
        drv_q[who].push_back({1'b1, 8'($urandom)});
      end
      predict(s_end);
      start();
      while (cyc < s_end + 3) step();
      compare_events("rand");
      check("rand_idle", 64'(busy), 64'(0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/simple_uart_tx_arbiter.md
# simple_uart_tx_arbiter

Shares the transmit side of one `simple_uart` instance between `NREQ` byte-stream requesters. Arbitration is per message: a granted requester keeps the UART until it sends a byte flagged `last`. `simple_uart` has no TX-busy output, so this block paces writes by counting a fixed byte period derived from `SYSTEM_FREQ`/`BAUD_RATE`. It sits between the on-chip producers (debug, log, command reply) and `simple_uart.tx_value`/`tx_value_write`.

## Interface
- `SYSTEM_FREQ`, 50_000_000, clock frequency in Hz; must match the UART instance.
- `BAUD_RATE`, 9600, baud rate; must match the UART instance.
- `NREQ`, 4, number of requesters, legal range 2..8.

- `clock`  in  1  single clock; every register is clocked on the rising edge.
- `arst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  NREQ  per-requester byte valid.
- `req_data`  in  8*NREQ  requester i byte on bits [8i+7:8i].
- `req_last`  in  NREQ  byte is the final byte of the message.
- `req_ready`  out  NREQ  byte accepted when `valid & ready`.
- `grant`  out  NREQ  one-hot current owner, all zero when idle.
- `busy`  out  1  high when the FSM is not in IDLE.
- `tx_value`  out  8  connects to UART `tx_value`.
- `tx_value_write`  out  1  one-cycle pulse; connects to UART `tx_value_write`.

## Operation
- `BIT_CYCLES = SYSTEM_FREQ / BAUD_RATE` (integer division).
- `BYTE_CYCLES = 11 * BIT_CYCLES`: 10 frame bits plus 1 guard bit.
- Elaboration fails if `BIT_CYCLES < 2` or `NREQ` is out of range.
- The gap counter is `$clog2(BYTE_CYCLES)` bits wide and counts down without wrapping.

FSM states:
- IDLE: `grant`=0.
  - If any `req_valid` bit is high, select the first requester with valid high, searching from `rr_ptr` upward modulo `NREQ`.
  - Register its one-hot `grant`, then go to SEND.
  - Otherwise stay in IDLE.
- SEND: `req_ready = grant` (combinational from state and grant).
  - On `req_valid[owner]`, register `tx_value <= req_data[owner]` and the last flag.
  - Load the counter with `BYTE_CYCLES-2`, then go to WAIT.
  - If the owner holds valid low, stay in SEND and keep the grant (message lock). There is no timeout.
  - Valid inputs from non-owners are ignored. Their `req_ready` stays 0.
- WAIT: the counter decrements each cycle. When it reaches 0:
  - Last flag clear: go to SEND.
  - Last flag set: set `rr_ptr <= owner+1` (modulo `NREQ`), clear `grant`, go to IDLE.
- `tx_value_write` is registered. It is high exactly in the cycle after each SEND acceptance.
- `tx_value` holds its value until the next acceptance.

## Timing
- Reset values:
  - `grant`=0, `req_ready`=0, `busy`=0
  - `tx_value`=8'h00, `tx_value_write`=0
  - `rr_ptr`=0, counter=0, state IDLE
- Asserting reset mid-message aborts immediately. The UART finishes any byte already written; no further write is issued.
- Valid high in IDLE at cycle 0:
  - `grant` and `req_ready` go high at cycle 1.
  - Acceptance happens at cycle 1 if valid is still high.
  - `tx_value_write` pulses at cycle 2.
- Acceptance at cycle t within a message: the earliest next `req_ready` is cycle t+`BYTE_CYCLES`. The spacing between consecutive `tx_value_write` pulses is therefore at least `BYTE_CYCLES`.
- Last byte accepted at cycle t: `grant`=0 at t+`BYTE_CYCLES` (IDLE), and a new grant at t+`BYTE_CYCLES`+1.
- Simultaneous valid from several requesters in IDLE: exactly one is granted, per `rr_ptr`.
- `req_last` on a message's first byte gives a single-byte message.

## Configuration
- `SIMPLE_UART_ARB_FIXED_PRIO_EN`
  - Defined: IDLE always searches from index 0, so the lowest index wins. `rr_ptr` is not implemented.
  - Undefined (default): round-robin as described in Operation.
- Pacing, message lock and all timing are identical in both builds.

## Test plan
All scenarios use `SYSTEM_FREQ`=1000, `BAUD_RATE`=100, `NREQ`=4, so `BIT_CYCLES`=10 and `BYTE_CYCLES`=110.
- Reset: hold `arst_n` low with random inputs -> all outputs 0. Release -> `busy` stays 0 while all valids are 0.
- Requester 2 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), valid held high from cycle 0:
  - `grant`=4'b0100 at cycle 1.
  - `tx_value_write` pulses at cycles 2, 112 and 222 with the matching bytes.
  - `grant`=0 at cycle 331.
- Requesters 0 and 1 each send one single-byte message, both valid at cycle 0:
  - Round-robin: req0 is granted first, req1 next at cycle 112.
  - Then a second req0 message with req1 valid again -> req1 wins.
  - With `SIMPLE_UART_ARB_FIXED_PRIO_EN` defined, req0 wins again.
- Owner stall: requester 3 drops valid after its first byte for 500 cycles while requester 0 is valid:
  - `grant` stays 4'b1000 throughout.
  - `req_ready[0]` stays 0.
  - Requester 3 resumes and sends its last byte; requester 0 is granted afterwards.
- Reset mid-message: assert `arst_n` low in WAIT during a 3-byte message -> outputs are 0 immediately, and no further `tx_value_write` occurs until a new request.
- Loopback: connect to `simple_uart` with `tx_bit` tied to `rx_bit` and send 16 bytes 0x00..0x0F from two requesters -> `rx_value` sequence matches the bytes in order of acceptance, with no byte lost or corrupted.
